// File: rtl/step_tick_gen.sv
// Tempo-driven step clock: turns a BPM setting into fixed-width Step pulses with a
// wrapping step index, phase-aligned to the shared nStart strobe.
module step_tick_gen #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned STEPS_PER_BEAT = 4,
  parameter int unsigned LOOP_STEPS     = 12,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned BPM_MIN        = 40,
  parameter int unsigned BPM_MAX        = 240
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       nStart,
  input  logic       Play,
  input  logic [7:0] Bpm,
  output logic       Step,
  output logic [3:0] StepIndex,
  output logic       LoopStart,
  output logic       Running
);

  localparam int unsigned AccW  = 33;
  localparam int unsigned PcntW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  localparam logic [AccW-1:0]  Thresh   = AccW'(CLK_HZ) * AccW'(60);
  localparam logic [AccW-1:0]  IncReset = AccW'(BPM_MIN * STEPS_PER_BEAT);
  localparam logic [PcntW-1:0] PcntLoad = PcntW'(PULSE_CYCLES - 1);
  localparam logic [3:0]       LastIdx  = 4'(LOOP_STEPS - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;

  state_e           r_state, w_state_d;
  logic [AccW-1:0]  r_acc, w_acc_d;
  logic [AccW-1:0]  r_inc, w_inc_d;
  logic             r_step, w_step_d;
  logic [PcntW-1:0] r_pcnt, w_pcnt_d;
  logic [3:0]       r_idx, w_idx_d;
  logic             r_ls, w_ls_d;

  logic [7:0]      w_bpm_eff;
  logic [AccW-1:0] w_inc_new;
  logic [AccW-1:0] w_sum;
  logic            w_ovf;
  logic [3:0]      w_idx_next;

  always_comb begin
    if ({24'd0, Bpm} < BPM_MIN) begin
      w_bpm_eff = 8'(BPM_MIN);
    end else if ({24'd0, Bpm} > BPM_MAX) begin
      w_bpm_eff = 8'(BPM_MAX);
    end else begin
      w_bpm_eff = Bpm;
    end
  end

  assign w_inc_new  = AccW'(w_bpm_eff) * AccW'(STEPS_PER_BEAT);
  // Remainder is carried past the threshold so the long-term rate does not drift.
  assign w_sum      = r_acc + r_inc;
  assign w_ovf      = (w_sum >= Thresh);
  assign w_idx_next = (r_idx >= LastIdx) ? 4'd0 : r_idx + 4'd1;

  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    w_inc_d   = r_inc;
    w_step_d  = r_step;
    w_pcnt_d  = r_pcnt;
    w_idx_d   = r_idx;
    w_ls_d    = 1'b0;

    if (r_pcnt != '0) begin
      w_pcnt_d = r_pcnt - PcntW'(1);
    end else begin
      w_step_d = 1'b0;
    end

    // nStart low restarts from any state and outranks ticks and Play.
    if (!nStart) begin
      w_state_d = StArmed;
      w_acc_d   = '0;
      w_idx_d   = 4'd0;
      w_step_d  = 1'b0;
      w_pcnt_d  = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_d = StIdle;
        end
        StArmed: begin
          if (Play) begin
            w_state_d = StRun;
            w_acc_d   = '0;
            w_inc_d   = w_inc_new;
            w_step_d  = 1'b1;
            w_pcnt_d  = PcntLoad;
            w_idx_d   = 4'd0;
            w_ls_d    = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end
        StRun: begin
          if (!Play) begin
            w_state_d = StIdle;
            w_acc_d   = '0;
            w_step_d  = 1'b0;
            w_pcnt_d  = '0;
          end else if (w_ovf) begin
            w_acc_d  = w_sum - Thresh;
            w_inc_d  = w_inc_new;
            w_step_d = 1'b1;
            w_pcnt_d = PcntLoad;
            w_idx_d  = w_idx_next;
            w_ls_d   = (w_idx_next == 4'd0);
          end else begin
            w_acc_d = w_sum;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_inc   <= IncReset;
      r_step  <= 1'b0;
      r_pcnt  <= '0;
      r_idx   <= 4'd0;
      r_ls    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
      r_inc   <= w_inc_d;
      r_step  <= w_step_d;
      r_pcnt  <= w_pcnt_d;
      r_idx   <= w_idx_d;
      r_ls    <= w_ls_d;
    end
  end

  assign Step      = r_step;
  assign StepIndex = r_idx;
  assign LoopStart = r_ls;
  assign Running   = (r_state == StRun);

endmodule

// File: tb/tb_step_tick_gen.sv
// Bench for step_tick_gen: table-driven tempo runs plus hand-written start/stop/reset
// sequences, with Step events checked against a scoreboard of expected cycles.
`timescale 1ns/1ps
module tb_step_tick_gen;

  localparam int ClkHz       = 1000;
  localparam int Thresh      = ClkHz * 60;
  localparam int PulseCycles = 4;
  localparam int LoopSteps   = 12;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       n_start = 1'b1;
  logic       play = 1'b0;
  logic [7:0] bpm = 8'd120;
  logic       step;
  logic [3:0] step_index;
  logic       loop_start;
  logic       running;

  step_tick_gen #(
    .CLK_HZ         (ClkHz),
    .STEPS_PER_BEAT (4),
    .LOOP_STEPS     (LoopSteps),
    .PULSE_CYCLES   (PulseCycles),
    .BPM_MIN        (40),
    .BPM_MAX        (240)
  ) dut (
    .Clock     (clk),
    .nReset    (n_reset),
    .nStart    (n_start),
    .Play      (play),
    .Bpm       (bpm),
    .Step      (step),
    .StepIndex (step_index),
    .LoopStart (loop_start),
    .Running   (running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int idx;
    bit ls;
  } ev_t;

  typedef struct {
    int bpm;
    int nper;
    int exp_total;
  } vec_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  bit  allow_short = 1'b0;
  int  last_rise = 0;
  bit  mon_prev = 1'b0;
  int  mon_width = 0;
  ev_t mon_e;

  function automatic int inc_of(int b);
    int e;
    e = (b < 40) ? 40 : ((b > 240) ? 240 : b);
    return e * 4;
  endfunction

  // Drift-free schedule: the k-th tick after the start tick lands at ceil(k*T/INC).
  function automatic int tick_at(int b, int k);
    int i;
    i = inc_of(b);
    return (k * Thresh + i - 1) / i;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_ev(input int c, input int idx);
    ev_t e;
    e.cyc = c;
    e.idx = idx % LoopSteps;
    e.ls  = ((idx % LoopSteps) == 0);
    exp_q.push_back(e);
  endtask

  task automatic push_run(input int base, input int b, input int n);
    for (int k = 0; k <= n; k++) push_ev(base + tick_at(b, k), k);
  endtask

  task automatic start_run(input int b, output int base);
    bpm = 8'(b);
    play = 1'b1;
    n_start = 1'b0;
    repeat (3) @(negedge clk);
    n_start = 1'b1;
    base = cyc + 1;
  endtask

  task automatic wait_empty(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d steps still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic stop_run();
    repeat (6) @(negedge clk);
    play = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard side: every Step rise pops one expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (step && !mon_prev) begin
        mon_width = 1;
        last_rise = cyc;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_step: got step at cycle %0d idx %0d, required no step",
                   cyc, step_index);
        end else begin
          mon_e = exp_q.pop_front();
          if (cyc != mon_e.cyc || int'(step_index) != mon_e.idx || loop_start != mon_e.ls) begin
            n_fail++;
            $display("FAIL step_event: got cycle %0d idx %0d ls %0d, required cycle %0d idx %0d ls %0d",
                     cyc, step_index, loop_start, mon_e.cyc, mon_e.idx, mon_e.ls);
          end
        end
      end else begin
        if (step) mon_width++;
        if (!step && mon_prev) begin
          n_tests++;
          if (!allow_short && mon_width != PulseCycles) begin
            n_fail++;
            $display("FAIL pulse_width: got %0d, required %0d", mon_width, PulseCycles);
          end
          allow_short = 1'b0;
        end
        if (loop_start) begin
          n_tests++;
          n_fail++;
          $display("FAIL stray_loopstart: got 1 at cycle %0d, required 0", cyc);
        end
      end
      mon_prev = step;
    end
  end

  initial begin
    vec_t vecs[6];
    int   base;

    vecs[0] = '{120, 12, 1500};
    vecs[1] = '{250, 10, 625};
    vecs[2] = '{10, 3, 1125};
    vecs[3] = '{0, 2, 750};
    vecs[4] = '{255, 4, 250};
    vecs[5] = '{200, 3, 225};

    #3;
    check("reset_step", int'(step), 0);
    check("reset_index", int'(step_index), 0);
    check("reset_loopstart", int'(loop_start), 0);
    check("reset_running", int'(running), 0);
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_running", int'(running), 0);

    for (int v = 0; v < 6; v++) begin
      start_run(vecs[v].bpm, base);
      push_run(base, vecs[v].bpm, vecs[v].nper);
      wait_empty($sformatf("vec%0d_steps", v));
      check($sformatf("vec%0d_total", v), last_rise - base, vecs[v].exp_total);
      stop_run();
    end

    // Tempo change mid-period applies only from the next step.
    start_run(120, base);
    push_ev(base, 0);
    push_ev(base + 125, 1);
    push_ev(base + 125 + 250, 2);
    repeat (20) @(negedge clk);
    bpm = 8'd60;
    wait_empty("tempo_change");
    stop_run();

    // Drop Play while Step is high, then restart from index 0.
    start_run(120, base);
    push_run(base, 120, 2);
    wait_empty("drop_run");
    check("running_before_drop", int'(running), 1);
    check("step_before_drop", int'(step), 1);
    play = 1'b0;
    allow_short = 1'b1;
    @(negedge clk);
    check("step_after_drop", int'(step), 0);
    check("running_after_drop", int'(running), 0);
    repeat (300) @(negedge clk);
    start_run(120, base);
    push_run(base, 120, 0);
    wait_empty("restart_after_drop");
    check("running_after_restart", int'(running), 1);
    stop_run();

    // Restart mid-run at index 7, then reset during a pulse.
    start_run(120, base);
    push_run(base, 120, 7);
    wait_empty("run_to_7");
    repeat (30) @(negedge clk);
    check("index_before_restart", int'(step_index), 7);
    n_start = 1'b0;
    @(negedge clk);
    check("armed_running", int'(running), 0);
    check("armed_index", int'(step_index), 0);
    check("armed_step", int'(step), 0);
    repeat (2) @(negedge clk);
    n_start = 1'b1;
    base = cyc + 1;
    push_run(base, 120, 1);
    wait_empty("restart_mid_run");
    check("step_before_reset", int'(step), 1);
    check("index_before_reset", int'(step_index), 1);
    #2;
    allow_short = 1'b1;
    n_reset = 1'b0;
    #1;
    check("async_reset_step", int'(step), 0);
    check("async_reset_index", int'(step_index), 0);
    check("async_reset_loopstart", int'(loop_start), 0);
    check("async_reset_running", int'(running), 0);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (200) @(negedge clk);
    check("post_reset_running", int'(running), 0);
    check("post_reset_index", int'(step_index), 0);
    play = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
